reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/rf_pkg.sv | 9 +
 rtl/rf_scoreboard.sv | 46 ++++
 rtl/reg_file_sb.sv | 81 ++++++++
 tb/tb_reg_file_sb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and register-index type for the scoreboarded register file.
package rf_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with reserve/write priority and sticky double-reservation flag.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic                 rsv_en_i,
    input  logic [ADDR_W-1:0]    rsv_addr_i,
    output logic [2**ADDR_W-1:0] busy_o,
    output logic                 err_dbl_rsv_o
);

    logic [2**ADDR_W-1:0] busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 wr_ok, rsv_ok;

    always_comb begin
        wr_ok  = wr_en_i  && !(ZERO_REG && (wr_addr_i  == '0));
        rsv_ok = rsv_en_i && !(ZERO_REG && (rsv_addr_i == '0));
        busy_d = busy_q;
        // Clear before set so a same-cycle reservation of the written register wins.
        if (wr_ok)  busy_d[wr_addr_i]  = 1'b0;
        if (rsv_ok) busy_d[rsv_addr_i] = 1'b1;
        err_d = err_q | (rsv_ok && busy_q[rsv_addr_i] &&
                         !(wr_ok && (wr_addr_i == rsv_addr_i)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_o        = busy_q;
    assign err_dbl_rsv_o = err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with reservation scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data/busy to the read ports.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              err_dbl_rsv
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_ok;

    assign wr_ok = wr_en && !(ZERO_REG && (wr_addr == '0));

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .rsv_en_i      (rsv_en),
        .rsv_addr_i    (rsv_addr),
        .busy_o        (busy),
        .err_dbl_rsv_o (err_dbl_rsv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) rf_q[i] <= '0;
        end else if (wr_ok) begin
            rf_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = rf_q[rd_addr_a];
        rd_busy_a = busy[rd_addr_a];
        rd_data_b = rf_q[rd_addr_b];
        rd_busy_b = busy[rd_addr_b];
`ifdef RF_BYPASS_EN
        if (wr_ok && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
            rd_busy_a = rsv_en && (rsv_addr == wr_addr);
        end
        if (wr_ok && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
            rd_busy_b = rsv_en && (rsv_addr == wr_addr);
        end
`endif
        if (ZERO_REG && (rd_addr_a == '0)) begin
            rd_data_a = '0;
            rd_busy_a = 1'b0;
        end
        if (ZERO_REG && (rd_addr_b == '0)) begin
            rd_data_b = '0;
            rd_busy_b = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (default 32x32 and a 64-bit x 8 instance).
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0, rsv_addr = '0;
    logic [31:0] rd_data_a, rd_data_b, wr_data = '0;
    logic        rd_busy_a, rd_busy_b, err_dbl_rsv;
    logic        wr_en = 1'b0, rsv_en = 1'b0;

    logic [2:0]  w_rd_addr_a = '0, w_rd_addr_b = '0, w_wr_addr = '0, w_rsv_addr = '0;
    logic [63:0] w_rd_data_a, w_rd_data_b, w_wr_data = '0;
    logic        w_rd_busy_a, w_rd_busy_b, w_err;
    logic        w_wr_en = 1'b0, w_rsv_en = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .err_dbl_rsv(err_dbl_rsv)
    );

    reg_file_sb #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(1'b0)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(w_rd_addr_a), .rd_addr_b(w_rd_addr_b),
        .rd_data_a(w_rd_data_a), .rd_data_b(w_rd_data_b),
        .rd_busy_a(w_rd_busy_a), .rd_busy_b(w_rd_busy_b),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .rsv_en(w_rsv_en), .rsv_addr(w_rsv_addr), .err_dbl_rsv(w_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        rd_addr_a = 5'd5;
        total++; if (rd_data_a !== 32'h0) begin bad++; $display("FAIL reset_init_data got=%h exp=%h", rd_data_a, 32'h0); end
        total++; if (err_dbl_rsv !== 1'b0) begin bad++; $display("FAIL reset_init_err got=%b exp=0", err_dbl_rsv); end
        tick();
        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd6;
        total++; if (rd_data_a !== 32'hDEADBEEF) begin bad++; $display("FAIL reset_pre_write got=%h exp=%h", rd_data_a, 32'hDEADBEEF); end
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        total++; if (rd_data_a !== 32'h0) begin bad++; $display("FAIL reset_async_data got=%h exp=%h", rd_data_a, 32'h0); end
        for (int i = 0; i < 32; i++) begin
            rd_addr_b = 5'(i);
            #1;
            total++; if (rd_busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy r%0d got=%b exp=0", i, rd_busy_b); end
        end
        total++; if (err_dbl_rsv !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_dbl_rsv); end
        // Operations presented while reset is held must be discarded.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFEF00D;
        rsv_en = 1'b1; rsv_addr = 5'd5;
        tick();
        idle();
        rst_n = 1'b1;
        tick();
        rd_addr_a = 5'd5;
        #1;
        total++; if (rd_data_a !== 32'h0) begin bad++; $display("FAIL reset_discard_data got=%h exp=%h", rd_data_a, 32'h0); end
        total++; if (rd_busy_a !== 1'b0) begin bad++; $display("FAIL reset_discard_busy got=%b exp=0", rd_busy_a); end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        idle();
        rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        #1;
        total++; if (rd_data_a !== 32'h0) begin bad++; $display("FAIL zero_data got=%h exp=%h", rd_data_a, 32'h0); end
        total++; if (rd_busy_b !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b exp=0", rd_busy_b); end
        total++; if (err_dbl_rsv !== 1'b0) begin bad++; $display("FAIL zero_err got=%b exp=0", err_dbl_rsv); end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        idle();
        rd_addr_a = 5'd7;
        #1;
        total++; if (rd_busy_a !== 1'b1) begin bad++; $display("FAIL sb_rsv_busy got=%b exp=1", rd_busy_a); end
        total++; if (err_dbl_rsv !== 1'b0) begin bad++; $display("FAIL sb_rsv_err got=%b exp=0", err_dbl_rsv); end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        tick();
        idle();
        total++; if (rd_busy_a !== 1'b0) begin bad++; $display("FAIL sb_wr_busy got=%b exp=0", rd_busy_a); end
        total++; if (rd_data_a !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wr_data got=%h exp=%h", rd_data_a, 32'hA5A5A5A5); end
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h55;
        tick();
        idle();
        rd_addr_b = 5'd12;
        #1;
        total++; if (rd_busy_b !== 1'b0 || rd_data_b !== 32'h55) begin bad++; $display("FAIL sb_nonbusy_wr got=%b/%h exp=0/%h", rd_busy_b, rd_data_b, 32'h55); end
        rsv_en = 1'b1; rsv_addr = 5'd11;
        tick();
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h77;
        tick();
        idle();
        rd_addr_b = 5'd11;
        #1;
        total++; if (rd_busy_b !== 1'b1 || rd_data_b !== 32'h77) begin bad++; $display("FAIL sb_rersv_with_wr got=%b/%h exp=1/%h", rd_busy_b, rd_data_b, 32'h77); end
        total++; if (err_dbl_rsv !== 1'b0) begin bad++; $display("FAIL sb_rersv_with_wr_err got=%b exp=0", err_dbl_rsv); end
    endtask

    task automatic test_dbl_rsv();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        rd_addr_a = 5'd9;
        #1;
        total++; if (rd_busy_a !== 1'b1) begin bad++; $display("FAIL dbl_same_busy got=%b exp=1", rd_busy_a); end
        total++; if (rd_data_a !== 32'h11) begin bad++; $display("FAIL dbl_same_data got=%h exp=%h", rd_data_a, 32'h11); end
        total++; if (err_dbl_rsv !== 1'b0) begin bad++; $display("FAIL dbl_same_err got=%b exp=0", err_dbl_rsv); end
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        total++; if (err_dbl_rsv !== 1'b1) begin bad++; $display("FAIL dbl_err_set got=%b exp=1", err_dbl_rsv); end
        total++; if (rd_busy_a !== 1'b1) begin bad++; $display("FAIL dbl_busy_hold got=%b exp=1", rd_busy_a); end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h22;
        tick();
        idle();
        tick();
        tick();
        total++; if (err_dbl_rsv !== 1'b1) begin bad++; $display("FAIL dbl_err_sticky got=%b exp=1", err_dbl_rsv); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_d;
        logic        exp_b;
`ifdef RF_BYPASS_EN
        exp_d = 32'h2; exp_b = 1'b0;
`else
        exp_d = 32'h1; exp_b = 1'b1;
`endif
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1;
        tick();
        wr_data = 32'h2;
        rd_addr_a = 5'd3;
        #1;
        total++; if (rd_data_a !== exp_d) begin bad++; $display("FAIL bypass_data got=%h exp=%h", rd_data_a, exp_d); end
        tick();
        idle();
        total++; if (rd_data_a !== 32'h2) begin bad++; $display("FAIL bypass_after_edge got=%h exp=%h", rd_data_a, 32'h2); end
        rsv_en = 1'b1; rsv_addr = 5'd4;
        tick();
        idle();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        rd_addr_b = 5'd4;
        #1;
        total++; if (rd_busy_b !== exp_b) begin bad++; $display("FAIL bypass_busy got=%b exp=%b", rd_busy_b, exp_b); end
        tick();
        idle();
        total++; if (rd_busy_b !== 1'b0 || rd_data_b !== 32'h44) begin bad++; $display("FAIL bypass_busy_after got=%b/%h exp=0/%h", rd_busy_b, rd_data_b, 32'h44); end
    endtask

    task automatic test_sweep64();
        logic [63:0] exp;
        for (int i = 0; i < 8; i++) begin
            w_wr_en = 1'b1; w_wr_addr = 3'(i);
            w_wr_data = {32'hC0DE0000 + 32'(i), 32'h11111111 * 32'(i + 1)};
            tick();
        end
        w_wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_rd_addr_a = 3'(i);
            w_rd_addr_b = 3'(7 - i);
            #1;
            exp = {32'hC0DE0000 + 32'(i), 32'h11111111 * 32'(i + 1)};
            total++; if (w_rd_data_a !== exp) begin bad++; $display("FAIL sweep_a r%0d got=%h exp=%h", i, w_rd_data_a, exp); end
            exp = {32'hC0DE0000 + 32'(7 - i), 32'h11111111 * 32'(8 - i)};
            total++; if (w_rd_data_b !== exp) begin bad++; $display("FAIL sweep_b r%0d got=%h exp=%h", 7 - i, w_rd_data_b, exp); end
        end
    endtask

    task automatic test_err_reset();
        #2 rst_n = 1'b0;
        #1;
        total++; if (err_dbl_rsv !== 1'b0) begin bad++; $display("FAIL err_reset got=%b exp=0", err_dbl_rsv); end
        rd_addr_a = 5'd9;
        #1;
        total++; if (rd_busy_a !== 1'b0 || rd_data_a !== 32'h0) begin bad++; $display("FAIL err_reset_r9 got=%b/%h exp=0/0", rd_busy_a, rd_data_a); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_scoreboard();
        test_dbl_rsv();
        test_bypass();
        test_sweep64();
        test_err_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
